// File: rtl/fetch_sequencer.sv
// fetch_sequencer: PC-advance and instruction-fetch handshake sequencer with
// redirect, pipeline-stall hold, halt/resume and a fetch-timeout watchdog.
`default_nettype none

module fetch_sequencer #(
  parameter logic [31:0] RESET_VECTOR = 32'h0,
  parameter int          WAIT_W       = 4,
  parameter int          MAX_WAIT     = 15
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] cur_pc,
  output logic [31:0] next_pc,
  output logic        pc_stall,
  output logic        pc_confirm,
  output logic        pc_hlt,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        pipe_stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        halt_req,
  input  logic        resume,
  output logic [31:0] instr,
  output logic        instr_valid,
  output logic        timeout
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_FETCH  = 2'd1,
    S_HOLD   = 2'd2,
    S_HALTED = 2'd3
  } state_t;

  localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(MAX_WAIT);
  localparam logic [WAIT_W-1:0] WAIT_ONE   = WAIT_W'(1);

  state_t            state_q, state_d;
  logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic [31:0]       latch_q, latch_d;
  logic              timeout_q, timeout_d;
  logic [31:0]       redirect_target;
  logic [31:0]       seq_pc;

  // Redirect targets are forced word-aligned; low bits are simply masked.
  assign redirect_target = redirect_pc & 32'hFFFF_FFFC;
  assign seq_pc          = cur_pc + 32'd4;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      wait_cnt_q <= '0;
      latch_q    <= 32'h0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      latch_q    <= latch_d;
      timeout_q  <= timeout_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    wait_cnt_d  = wait_cnt_q;
    latch_d     = latch_q;
    timeout_d   = timeout_q;
    next_pc     = cur_pc;
    pc_confirm  = 1'b0;
    instr       = latch_q;
    instr_valid = 1'b0;
    imem_req    = 1'b0;

    case (state_q)
      S_IDLE: begin
        next_pc    = RESET_VECTOR;
        state_d    = S_FETCH;
        wait_cnt_d = '0;
      end

      S_FETCH: begin
        imem_req = 1'b1;
        if (halt_req) begin
          state_d    = S_HALTED;
          wait_cnt_d = '0;
        end else if (redirect_valid) begin
          // Any same-cycle ack belongs to the squashed path and is dropped.
          pc_confirm = 1'b1;
          next_pc    = redirect_target;
          wait_cnt_d = '0;
        end else if (imem_ack) begin
          instr       = imem_rdata;
          instr_valid = 1'b1;
          wait_cnt_d  = '0;
          if (!pipe_stall) begin
            pc_confirm = 1'b1;
            next_pc    = seq_pc;
          end else begin
            latch_d = imem_rdata;
            state_d = S_HOLD;
          end
        end else if (wait_cnt_q == WAIT_LIMIT) begin
          timeout_d  = 1'b1;
          state_d    = S_HALTED;
          wait_cnt_d = '0;
        end else begin
          wait_cnt_d = wait_cnt_q + WAIT_ONE;
        end
      end

      S_HOLD: begin
        instr       = latch_q;
        instr_valid = 1'b1;
        if (halt_req) begin
          instr_valid = 1'b0;
          state_d     = S_HALTED;
        end else if (redirect_valid) begin
          instr_valid = 1'b0;
          pc_confirm  = 1'b1;
          next_pc     = redirect_target;
          wait_cnt_d  = '0;
          state_d     = S_FETCH;
        end else if (!pipe_stall) begin
          pc_confirm = 1'b1;
          next_pc    = seq_pc;
          wait_cnt_d = '0;
          state_d    = S_FETCH;
        end
      end

      S_HALTED: begin
        // A timeout halt is terminal until reset.
        if (resume && !timeout_q) begin
          state_d    = S_FETCH;
          wait_cnt_d = '0;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign pc_stall  = 1'b1;
  assign pc_hlt    = (state_q == S_HALTED);
  assign imem_addr = cur_pc;
  assign timeout   = timeout_q;

endmodule

`default_nettype wire
